info_frame_builder: RTL and testbench

- Runtime-programmable, multi-slot InfoFrame packet source. It generalises the fixed, parameter-built AVI InfoFrame: each slot's type, version, length and payload bytes are written at run time.
- Checksums are computed sequentially, one byte per clock. Committed frames are double-buffered.
- Once per requested frame, each enabled slot's packet is offered over a valid/ready handshake to the HDMI packet picker.

---
 rtl/info_frame_builder.sv | 160 ++++++++++++++++
 tb/tb_info_frame_builder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/info_frame_builder.sv
// Runtime-programmable multi-slot InfoFrame source: per-slot staging bytes, a serial
// checksum/commit engine and a valid/ready sender that walks the enabled slots per frame.
module info_frame_builder #(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic                  cfg_wr_en,
  input  logic [SLOT_W-1:0]     cfg_slot,
  input  logic [4:0]            cfg_addr,
  input  logic [7:0]            cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  input  logic [NUM_SLOTS-1:0]  slot_enable,
  input  logic                  frame_start,
  output logic                  packet_valid,
  input  logic                  packet_ready,
  output logic [SLOT_W-1:0]     packet_slot,
  output logic [23:0]           header,
  output logic [3:0][55:0]      sub
);

  typedef enum logic [1:0] {C_IDLE, C_SUM, C_SWAP} c_state_t;
  typedef enum logic {S_IDLE, S_PRESENT} s_state_t;

  c_state_t c_state;
  s_state_t s_state;

  logic [7:0]           stg [NUM_SLOTS][30];
  logic [23:0]          act_hdr [NUM_SLOTS];
  logic [3:0][55:0]     act_sub [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] active_valid;
  logic [NUM_SLOTS-1:0] pending;

  logic [SLOT_W-1:0] c_slot;
  logic [4:0]        c_idx;
  logic [7:0]        acc;
  logic [4:0]        l_eff;
  logic [7:0]        sum_byte;
  logic [7:0]        pb [28];
  logic [23:0]       swap_hdr;
  logic [3:0][55:0]  swap_sub;
  logic              swap_stall;

  logic                 handshake;
  logic [NUM_SLOTS-1:0] pend_clr;
  logic [NUM_SLOTS-1:0] pend_next;
  logic [SLOT_W-1:0]    sel_idle;
  logic [SLOT_W-1:0]    sel_next;

  function automatic logic [SLOT_W-1:0] lowest(input logic [NUM_SLOTS-1:0] m);
    lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (m[i]) lowest = SLOT_W'(i);
  endfunction

  always_comb begin
    l_eff = (stg[c_slot][2][4:0] > 5'd27) ? 5'd27 : stg[c_slot][2][4:0];
    sum_byte = stg[c_slot][c_idx];
    if (c_idx >= 5'd3 && (c_idx - 5'd2) > l_eff) sum_byte = 8'h00;

    // PB0 makes the full header+payload sum wrap to zero
    pb[0] = 8'h00 - acc;
    for (int n = 1; n < 28; n++)
      pb[n] = (n <= int'(l_eff)) ? stg[c_slot][n + 2] : 8'h00;
    swap_hdr = {stg[c_slot][2], stg[c_slot][1], stg[c_slot][0]};
    swap_sub = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 7; j++)
        swap_sub[i][8*j +: 8] = pb[7*i + j];

    swap_stall = packet_valid && (packet_slot == c_slot) && !packet_ready;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      c_state      <= C_IDLE;
      cfg_busy     <= 1'b0;
      c_slot       <= '0;
      c_idx        <= '0;
      acc          <= '0;
      active_valid <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        act_hdr[s] <= '0;
        act_sub[s] <= '0;
        for (int a = 0; a < 30; a++) stg[s][a] <= '0;
      end
    end else begin
      if (cfg_wr_en && !cfg_busy && cfg_addr < 5'd30)
        stg[cfg_slot][cfg_addr] <= (cfg_addr == 5'd0) ? (cfg_data | 8'h80) : cfg_data;
      case (c_state)
        C_IDLE: if (cfg_commit) begin
          c_slot   <= cfg_slot;
          acc      <= '0;
          c_idx    <= '0;
          cfg_busy <= 1'b1;
          c_state  <= C_SUM;
        end
        C_SUM: begin
          acc   <= acc + sum_byte;
          c_idx <= c_idx + 5'd1;
          if (c_idx == 5'd29) c_state <= C_SWAP;
        end
        C_SWAP: if (!swap_stall) begin
          act_hdr[c_slot]      <= swap_hdr;
          act_sub[c_slot]      <= swap_sub;
          active_valid[c_slot] <= 1'b1;
          cfg_busy             <= 1'b0;
          c_state              <= C_IDLE;
        end
        default: c_state <= C_IDLE;
      endcase
    end
  end

  // Accepted slot is cleared before a coincident frame_start re-queues it
  always_comb begin
    handshake = packet_valid && packet_ready;
    pend_clr  = pending;
    if (handshake) pend_clr[packet_slot] = 1'b0;
    pend_next = pend_clr | (frame_start ? (slot_enable & active_valid) : '0);
    sel_idle  = lowest(pending);
    sel_next  = lowest(pend_next);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      s_state      <= S_IDLE;
      pending      <= '0;
      packet_valid <= 1'b0;
      packet_slot  <= '0;
      header       <= '0;
      sub          <= '0;
    end else begin
      pending <= pend_next;
      case (s_state)
        S_IDLE: if (pending != '0) begin
          packet_slot  <= sel_idle;
          header       <= act_hdr[sel_idle];
          sub          <= act_sub[sel_idle];
          packet_valid <= 1'b1;
          s_state      <= S_PRESENT;
        end
        S_PRESENT: if (handshake) begin
          if (pend_next != '0) begin
            packet_slot <= sel_next;
            header      <= act_hdr[sel_next];
            sub         <= act_sub[sel_next];
          end else begin
            packet_valid <= 1'b0;
            s_state      <= S_IDLE;
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_info_frame_builder.sv
// Directed + randomized bench for info_frame_builder against a byte-array reference model.
module tb_info_frame_builder;
  localparam int NUM_SLOTS = 2;
  localparam int SLOT_W    = 1;

  logic                 clk_pixel = 1'b0;
  logic                 reset = 1'b1;
  logic                 cfg_wr_en = 1'b0;
  logic [SLOT_W-1:0]    cfg_slot = '0;
  logic [4:0]           cfg_addr = '0;
  logic [7:0]           cfg_data = '0;
  logic                 cfg_commit = 1'b0;
  logic                 cfg_busy;
  logic [NUM_SLOTS-1:0] slot_enable = '0;
  logic                 frame_start = 1'b0;
  logic                 packet_valid;
  logic                 packet_ready = 1'b0;
  logic [SLOT_W-1:0]    packet_slot;
  logic [23:0]          header;
  logic [3:0][55:0]     sub;

  info_frame_builder #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_slot(cfg_slot),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .slot_enable(slot_enable), .frame_start(frame_start), .packet_valid(packet_valid),
    .packet_ready(packet_ready), .packet_slot(packet_slot), .header(header), .sub(sub)
  );

  always #5 clk_pixel = ~clk_pixel;

  int passed = 0;
  int total  = 0;

  logic [7:0]           m_stg [NUM_SLOTS][30];
  logic [23:0]          m_hdr [NUM_SLOTS];
  logic [223:0]         m_sub [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] m_valid = '0;
  logic [23:0]          last_hdr [NUM_SLOTS];
  logic [223:0]         last_sub [NUM_SLOTS];

  task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m_clear();
    for (int s = 0; s < NUM_SLOTS; s++)
      for (int a = 0; a < 30; a++) m_stg[s][a] = 8'h00;
    m_valid = '0;
  endtask

  // Checksum rule: header + first L payload bytes + PB0 sum to 0 mod 256
  task automatic m_commit(input int s);
    int l, sum;
    logic [7:0] p [28];
    l = int'(m_stg[s][2] & 8'h1F);
    if (l > 27) l = 27;
    sum = int'(m_stg[s][0]) + int'(m_stg[s][1]) + int'(m_stg[s][2]);
    for (int n = 1; n < 28; n++) begin
      p[n] = (n <= l) ? m_stg[s][n + 2] : 8'h00;
      sum += int'(p[n]);
    end
    p[0] = 8'((256 - (sum % 256)) % 256);
    m_hdr[s] = {m_stg[s][2], m_stg[s][1], m_stg[s][0]};
    m_sub[s] = '0;
    for (int n = 0; n < 28; n++) m_sub[s][8*n +: 8] = p[n];
    m_valid[s] = 1'b1;
  endtask

  task automatic wr(input int s, input int a, input logic [7:0] d);
    cfg_slot = SLOT_W'(s); cfg_addr = 5'(a); cfg_data = d; cfg_wr_en = 1'b1;
    @(negedge clk_pixel);
    cfg_wr_en = 1'b0;
    if (a < 30) m_stg[s][a] = (a == 0) ? (d | 8'h80) : d;
  endtask

  task automatic do_commit(input int s, input bit inject);
    int n;
    n = 0;
    cfg_slot = SLOT_W'(s); cfg_commit = 1'b1;
    @(negedge clk_pixel);
    cfg_commit = 1'b0;
    while (cfg_busy === 1'b1 && n < 100) begin
      if (inject && n == 3) begin
        cfg_wr_en = 1'b1; cfg_addr = 5'd3; cfg_data = 8'hAA; cfg_commit = 1'b1;
      end
      @(negedge clk_pixel);
      n++;
      cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    end
    chk("busy_cycles", n, 31);
    m_commit(s);
  endtask

  task automatic send(input logic [NUM_SLOTS-1:0] en);
    int n, extra;
    slot_enable = en; packet_ready = 1'b1; frame_start = 1'b1;
    @(negedge clk_pixel);
    frame_start = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (en[s] && m_valid[s]) begin
        n = 0;
        while (packet_valid !== 1'b1 && n < 10) begin
          @(negedge clk_pixel);
          n++;
        end
        chk("pkt_timeout", (n < 10), 1);
        chk("pkt_slot", packet_slot, s);
        chk("pkt_header", header, m_hdr[s]);
        chk("pkt_sub", sub, m_sub[s]);
        last_hdr[s] = header;
        last_sub[s] = sub;
        @(negedge clk_pixel);
      end
    end
    extra = 0;
    repeat (4) begin
      if (packet_valid !== 1'b0) extra++;
      @(negedge clk_pixel);
    end
    chk("pkt_extra", extra, 0);
    packet_ready = 1'b0;
  endtask

  task automatic write_avi();
    for (int a = 0; a < 30; a++) wr(0, a, 8'h00);
    wr(0, 0, 8'h02); wr(0, 1, 8'h02); wr(0, 2, 8'h0D); wr(0, 6, 8'h01);
  endtask

  initial begin
    int n, s;
    logic [23:0]  keep_hdr;
    logic [223:0] keep_sub;
    logic [NUM_SLOTS-1:0] en;

    m_clear();
    repeat (3) @(negedge clk_pixel);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_valid", packet_valid, 0);
    chk("rst_slot", packet_slot, 0);
    chk("rst_header", header, 0);
    chk("rst_sub", sub, 0);
    reset = 1'b0;
    @(negedge clk_pixel);

    // AVI slot 0
    write_avi();
    do_commit(0, 1'b0);
    send(2'b01);
    chk("avi_header", last_hdr[0], 24'h0D0282);
    chk("avi_sub", last_sub[0], {168'h0, 56'h0000010000006E});

    // reset while a commit is summing
    cfg_slot = 1'b1; cfg_commit = 1'b1;
    @(negedge clk_pixel);
    cfg_commit = 1'b0;
    repeat (5) @(negedge clk_pixel);
    reset = 1'b1;
    @(negedge clk_pixel);
    chk("midsum_busy", cfg_busy, 0);
    chk("midsum_valid", packet_valid, 0);
    reset = 1'b0;
    m_clear();
    @(negedge clk_pixel);
    send(2'b11);

    // length clamp and mask
    write_avi();
    wr(0, 22, 8'hFF);
    do_commit(0, 1'b0);
    send(2'b01);
    chk("clamp_sub2", last_sub[0][167:112], 0);
    chk("clamp_pb0", last_sub[0][7:0], 8'h6E);
    wr(0, 22, 8'h00); wr(0, 2, 8'h1F); wr(0, 29, 8'h01);
    do_commit(0, 1'b0);
    send(2'b01);
    chk("l27_pb27", last_sub[0][223:216], 8'h01);
    chk("l27_pb0", last_sub[0][7:0], 8'h5B);

    // multi-slot ordering with random slot 1 contents
    for (int a = 0; a < 30; a++) wr(1, a, 8'($urandom));
    do_commit(1, 1'b0);
    slot_enable = 2'b11; packet_ready = 1'b0; frame_start = 1'b1;
    @(negedge clk_pixel);
    frame_start = 1'b0;
    n = 0;
    while (packet_valid !== 1'b1 && n < 10) begin
      @(negedge clk_pixel);
      n++;
    end
    chk("multi_timeout", (n < 10), 1);
    chk("multi_s0_slot", packet_slot, 0);
    chk("multi_s0_sub", sub, m_sub[0]);
    repeat (4) begin
      @(negedge clk_pixel);
      chk("multi_hold_valid", packet_valid, 1);
      chk("multi_hold_slot", packet_slot, 0);
      chk("multi_hold_header", header, m_hdr[0]);
    end
    packet_ready = 1'b1;
    @(negedge clk_pixel);
    chk("multi_s1_valid", packet_valid, 1);
    chk("multi_s1_slot", packet_slot, 1);
    chk("multi_s1_header", header, m_hdr[1]);
    chk("multi_s1_sub", sub, m_sub[1]);
    @(negedge clk_pixel);
    chk("multi_done", packet_valid, 0);
    packet_ready = 1'b0;

    // swap stall while slot 0 is on offer
    slot_enable = 2'b01; frame_start = 1'b1;
    @(negedge clk_pixel);
    frame_start = 1'b0;
    n = 0;
    while (packet_valid !== 1'b1 && n < 10) begin
      @(negedge clk_pixel);
      n++;
    end
    chk("stall_timeout", (n < 10), 1);
    keep_hdr = m_hdr[0];
    keep_sub = m_sub[0];
    wr(0, 1, 8'h03); wr(0, 3, 8'($urandom)); wr(0, 4, 8'($urandom));
    cfg_slot = 1'b0; cfg_commit = 1'b1;
    @(negedge clk_pixel);
    cfg_commit = 1'b0;
    repeat (40) @(negedge clk_pixel);
    chk("stall_busy", cfg_busy, 1);
    chk("stall_valid", packet_valid, 1);
    chk("stall_header", header, keep_hdr);
    chk("stall_sub", sub, keep_sub);
    packet_ready = 1'b1;
    @(negedge clk_pixel);
    packet_ready = 1'b0;
    chk("stall_release_busy", cfg_busy, 0);
    chk("stall_release_valid", packet_valid, 0);
    m_commit(0);
    send(2'b01);

    // writes and commits during a busy period
    do_commit(1, 1'b1);
    n = 0;
    repeat (5) begin
      if (cfg_busy !== 1'b0) n++;
      @(negedge clk_pixel);
    end
    chk("busy_no_second", n, 0);
    do_commit(1, 1'b0);
    send(2'b10);

    // random programming rounds
    for (int r = 0; r < 4; r++) begin
      s = int'($urandom_range(0, NUM_SLOTS - 1));
      repeat (6) wr(s, int'($urandom_range(0, 31)), 8'($urandom));
      do_commit(s, 1'b0);
      en = NUM_SLOTS'($urandom_range(1, 3));
      send(en);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
